segment_stepper: RTL

//  Consumes motion records from the record FIFO and emits step/direction pulses for one axis.
//  - Pops one record per segment via the FIFO read strobe.
//  - Generates N evenly spaced step pulses at a fixed period, then fetches the next record.
//  - Consecutive same-direction segments run back-to-back with no gap between step periods.

---
 rtl/segment_stepper.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/segment_stepper.sv
// segment_stepper: pops motion records from a record FIFO and turns each one
// into N evenly spaced step pulses on a single axis, with direction setup
// time inserted whenever the direction changes between segments.
//
// Handshake: fifo_read_en is a combinational pop strobe. The head record on
// fifo_data is consumed at the rising edge that ends the cycle in which
// fifo_read_en=1. fifo_data must be valid whenever fifo_empty=0. No pop is
// issued while reset=1 or enable=0.
module segment_stepper #(
    parameter int RECORD_SIZE_BITS = 128,
    parameter int PULSE_CLKS       = 4,
    parameter int DIR_SETUP_CLKS   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        fifo_empty,
    input  logic [RECORD_SIZE_BITS-1:0] fifo_data,
    output logic                        fifo_read_en,
    output logic                        step,
    output logic                        dir,
    output logic                        busy,
    output logic                        segment_done,
    output logic [31:0]                 steps_remaining,
    output logic [1:0]                  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // Shortest legal period leaves at least one low clock between pulses.
    localparam logic [31:0] MIN_PERIOD = 32'(PULSE_CLKS + 1);
    localparam logic [31:0] PULSE_W    = 32'(PULSE_CLKS);
    localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP_CLKS - 1);

    logic [1:0]  r_state;
    logic [31:0] r_t;
    logic [31:0] r_period;
    logic [31:0] r_remaining;
    logic [31:0] r_setup_cnt;
    logic        r_step;
    logic        r_dir;
    logic        r_done;

    logic [31:0] w_rec_n;
    logic [31:0] w_rec_p_raw;
    logic [31:0] w_rec_p;
    logic        w_rec_dir;
    logic        w_unused_bits;
    logic        w_period_end;
    logic        w_last_run;
    logic        w_fetch_point;
    logic        w_fetch;

    logic [1:0]  w_next_state;
    logic [31:0] w_next_t;
    logic [31:0] w_next_period;
    logic [31:0] w_next_rem;
    logic [31:0] w_next_setup;
    logic        w_next_dir;
    logic        w_next_done;

    // Record field extraction; bits above the direction flag carry nothing.
    assign w_rec_n       = fifo_data[31:0];
    assign w_rec_p_raw   = fifo_data[63:32];
    assign w_rec_dir     = fifo_data[64];
    assign w_unused_bits = ^fifo_data[RECORD_SIZE_BITS-1:65];
    assign w_rec_p       = (w_rec_p_raw < MIN_PERIOD) ? MIN_PERIOD : w_rec_p_raw;

    // The last clock of the last step period doubles as a fetch slot so a
    // queued same-direction record continues with no gap.
    assign w_period_end  = (r_t == r_period - 32'd1);
    assign w_last_run    = (r_state == ST_RUN) && w_period_end && (r_remaining == 32'd1);
    assign w_fetch_point = (r_state == ST_IDLE) || w_last_run;
    assign w_fetch       = w_fetch_point && enable && !fifo_empty && !reset;

    // Next-state logic: normal sequencing first, a fetch then overrides it.
    always_comb begin
        w_next_state  = r_state;
        w_next_t      = r_t;
        w_next_period = r_period;
        w_next_rem    = r_remaining;
        w_next_setup  = r_setup_cnt;
        w_next_dir    = r_dir;
        w_next_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            ST_SETUP: begin
                if (r_setup_cnt == SETUP_LAST) begin
                    w_next_state = ST_RUN;
                    w_next_t     = 32'd0;
                end else begin
                    w_next_setup = r_setup_cnt + 32'd1;
                end
            end
            ST_RUN: begin
                if (w_period_end) begin
                    w_next_t   = 32'd0;
                    w_next_rem = r_remaining - 32'd1;
                    if (r_remaining == 32'd1) begin
                        w_next_done  = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_t = r_t + 32'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_fetch) begin
            w_next_period = w_rec_p;
            w_next_rem    = w_rec_n;
            w_next_t      = 32'd0;
            w_next_setup  = 32'd0;
            if (w_rec_n == 32'd0) begin
                w_next_done  = 1'b1;
                w_next_state = ST_IDLE;
            end else if (w_rec_dir != r_dir) begin
                w_next_dir   = w_rec_dir;
                w_next_state = ST_SETUP;
            end else begin
                w_next_state = ST_RUN;
            end
        end
    end

    // State and output registers; step is registered from the next count so
    // it rises in the very first RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_t         <= 32'd0;
            r_period    <= 32'd0;
            r_remaining <= 32'd0;
            r_setup_cnt <= 32'd0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_t         <= w_next_t;
            r_period    <= w_next_period;
            r_remaining <= w_next_rem;
            r_setup_cnt <= w_next_setup;
            r_step      <= (w_next_state == ST_RUN) && (w_next_t < PULSE_W);
            r_dir       <= w_next_dir;
            r_done      <= w_next_done;
        end
    end

    assign fifo_read_en    = w_fetch;
    assign step            = r_step;
    assign dir             = r_dir;
    assign busy            = (r_state != ST_IDLE);
    assign segment_done    = r_done;
    assign steps_remaining = r_remaining;
    assign dbg_state       = r_state;

endmodule
